// File: rtl/operand_entry_fsm.sv
// Keypad operand entry: collects two BCD operands of up to three digits,
// converts them to binary and hands them to the adder with a start pulse.
module operand_entry_fsm #(
    parameter logic [3:0] KEY_ENTER = 4'hA,
    parameter logic [3:0] KEY_BACK  = 4'hB,
    parameter logic [3:0] KEY_CLEAR = 4'hC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        sum_valid,
    output logic [11:0] number1,
    output logic [11:0] number2,
    output logic        start_suma,
    output logic [11:0] entry_bcd,
    output logic [1:0]  digit_count,
    output logic        operand_sel,
    output logic        done
);

    typedef enum logic [2:0] {
        ENTRY_A,
        ENTRY_B,
        START,
        WAIT_SUM,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] num1_q, num1_d;
    logic [11:0] num2_q, num2_d;
    logic [11:0] bcd_q, bcd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;

    logic        is_digit, is_enter, is_back, is_clear;
    logic [11:0] bcd_value;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_enter = key_valid && (key_code == KEY_ENTER);
    assign is_back  = key_valid && (key_code == KEY_BACK);
    assign is_clear = key_valid && (key_code == KEY_CLEAR);

    // Max 9*100 + 9*10 + 9 = 999, so 12 bits never overflow.
    assign bcd_value = ({8'h00, bcd_q[11:8]} * 12'd100)
                     + ({8'h00, bcd_q[7:4]} * 12'd10)
                     + {8'h00, bcd_q[3:0]};

    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (is_clear) begin
            state_d = ENTRY_A;
            num1_d  = 12'h000;
            num2_d  = 12'h000;
            bcd_d   = 12'h000;
            cnt_d   = 2'd0;
            sel_d   = 1'b0;
        end else begin
            unique case (state_q)
                ENTRY_A, ENTRY_B: begin
                    if (is_digit && cnt_q != 2'd3) begin
                        bcd_d = {bcd_q[7:0], key_code};
                        cnt_d = cnt_q + 2'd1;
                    end else if (is_back && cnt_q != 2'd0) begin
                        bcd_d = {4'h0, bcd_q[11:4]};
                        cnt_d = cnt_q - 2'd1;
                    end else if (is_enter && cnt_q != 2'd0) begin
                        bcd_d = 12'h000;
                        cnt_d = 2'd0;
                        if (state_q == ENTRY_A) begin
                            num1_d  = bcd_value;
                            sel_d   = 1'b1;
                            state_d = ENTRY_B;
                        end else begin
                            num2_d  = bcd_value;
                            state_d = START;
                        end
                    end
                end
                START: state_d = WAIT_SUM;
                WAIT_SUM: begin
                    if (sum_valid) state_d = DONE;
                end
                DONE: begin
                    // A new digit starts a fresh calculation as the first digit of A.
                    if (is_digit) begin
                        num1_d  = 12'h000;
                        num2_d  = 12'h000;
                        bcd_d   = {8'h00, key_code};
                        cnt_d   = 2'd1;
                        sel_d   = 1'b0;
                        state_d = ENTRY_A;
                    end
                end
                default: state_d = ENTRY_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY_A;
            num1_q  <= 12'h000;
            num2_q  <= 12'h000;
            bcd_q   <= 12'h000;
            cnt_q   <= 2'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign number1     = num1_q;
    assign number2     = num2_q;
    assign entry_bcd   = bcd_q;
    assign digit_count = cnt_q;
    assign operand_sel = sel_q;
    assign start_suma  = (state_q == START);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed vector bench for operand_entry_fsm: table of key/sum_valid
// stimuli with hand-computed outputs, plus reset/clear corner sequences.
module tb_operand_entry_fsm;

    localparam logic [3:0] EN = 4'hA;
    localparam logic [3:0] BK = 4'hB;
    localparam logic [3:0] CL = 4'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        sum_valid = 1'b0;
    logic [11:0] number1;
    logic [11:0] number2;
    logic        start_suma;
    logic [11:0] entry_bcd;
    logic [1:0]  digit_count;
    logic        operand_sel;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_entry_fsm dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .sum_valid(sum_valid),
        .number1(number1),
        .number2(number2),
        .start_suma(start_suma),
        .entry_bcd(entry_bcd),
        .digit_count(digit_count),
        .operand_sel(operand_sel),
        .done(done)
    );

    typedef struct {
        logic        rst;
        logic        kv;
        logic [3:0]  kc;
        logic        sv;
        logic [11:0] n1;
        logic [11:0] n2;
        logic        st;
        logic [11:0] bcd;
        logic [1:0]  cnt;
        logic        sel;
        logic        dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic kv, logic [3:0] kc,
                                logic sv, logic [11:0] n1, logic [11:0] n2,
                                logic st, logic [11:0] bcd, logic [1:0] cnt,
                                logic sel, logic dn);
        vec_t v;
        v.rst = rst; v.kv = kv; v.kc = kc; v.sv = sv;
        v.n1 = n1; v.n2 = n2; v.st = st; v.bcd = bcd;
        v.cnt = cnt; v.sel = sel; v.dn = dn;
        return v;
    endfunction

    // Key press with sum_valid low.
    function automatic vec_t key(logic [3:0] kc, logic [11:0] n1,
                                 logic [11:0] n2, logic st, logic [11:0] bcd,
                                 logic [1:0] cnt, logic sel, logic dn);
        return mk(1'b0, 1'b1, kc, 1'b0, n1, n2, st, bcd, cnt, sel, dn);
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [40:0] act, exp;
        reset     = v.rst;
        key_valid = v.kv;
        key_code  = v.kc;
        sum_valid = v.sv;
        @(posedge clk);
        #1;
        act = {number1, number2, start_suma, entry_bcd,
               digit_count, operand_sel, done};
        exp = {v.n1, v.n2, v.st, v.bcd, v.cnt, v.sel, v.dn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: n1=%0d n2=%0d st=%b bcd=%h cnt=%0d sel=%b dn=%b, want n1=%0d n2=%0d st=%b bcd=%h cnt=%0d sel=%b dn=%b",
                     name, number1, number2, start_suma, entry_bcd,
                     digit_count, operand_sel, done, v.n1, v.n2, v.st,
                     v.bcd, v.cnt, v.sel, v.dn);
        end
    endtask

    initial begin
        // reset, then 1,2,3,ENTER,4,5,ENTER
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(key(4'h1, 0, 0, 0, 12'h001, 1, 0, 0));
        tbl.push_back(key(4'h2, 0, 0, 0, 12'h012, 2, 0, 0));
        tbl.push_back(key(4'h3, 0, 0, 0, 12'h123, 3, 0, 0));
        tbl.push_back(key(EN, 123, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(4'h4, 123, 0, 0, 12'h004, 1, 1, 0));
        tbl.push_back(key(4'h5, 123, 0, 0, 12'h045, 2, 1, 0));
        tbl.push_back(key(EN, 123, 45, 1, 12'h000, 0, 1, 0));
        // sum_valid in START ignored, digit in WAIT_SUM ignored, no timeout
        tbl.push_back(mk(0, 1, 4'h7, 1, 123, 45, 0, 12'h000, 0, 1, 0));
        tbl.push_back(mk(0, 1, 4'h8, 0, 123, 45, 0, 12'h000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 123, 45, 0, 12'h000, 0, 1, 1));
        tbl.push_back(key(EN, 123, 45, 0, 12'h000, 0, 1, 1));
        tbl.push_back(key(BK, 123, 45, 0, 12'h000, 0, 1, 1));
        tbl.push_back(key(4'hE, 123, 45, 0, 12'h000, 0, 1, 1));
        tbl.push_back(key(4'h6, 0, 0, 0, 12'h006, 1, 0, 0));
        // clear, then 9,9,9,9,ENTER,9,9,9,ENTER
        tbl.push_back(key(CL, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(key(4'h9, 0, 0, 0, 12'h009, 1, 0, 0));
        tbl.push_back(key(4'h9, 0, 0, 0, 12'h099, 2, 0, 0));
        tbl.push_back(key(4'h9, 0, 0, 0, 12'h999, 3, 0, 0));
        tbl.push_back(key(4'h9, 0, 0, 0, 12'h999, 3, 0, 0));
        tbl.push_back(key(EN, 999, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(4'h9, 999, 0, 0, 12'h009, 1, 1, 0));
        tbl.push_back(key(4'h9, 999, 0, 0, 12'h099, 2, 1, 0));
        tbl.push_back(key(4'h9, 999, 0, 0, 12'h999, 3, 1, 0));
        tbl.push_back(key(EN, 999, 999, 1, 12'h000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 999, 999, 0, 12'h000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 999, 999, 0, 12'h000, 0, 1, 1));
        tbl.push_back(key(CL, 0, 0, 0, 12'h000, 0, 0, 0));
        // 7,8,BACK,5,ENTER then idle keys at count 0
        tbl.push_back(key(4'h7, 0, 0, 0, 12'h007, 1, 0, 0));
        tbl.push_back(key(4'h8, 0, 0, 0, 12'h078, 2, 0, 0));
        tbl.push_back(key(BK, 0, 0, 0, 12'h007, 1, 0, 0));
        tbl.push_back(key(4'h5, 0, 0, 0, 12'h075, 2, 0, 0));
        tbl.push_back(key(EN, 75, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(EN, 75, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(BK, 75, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(4'hD, 75, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h3, 0, 75, 0, 0, 12'h000, 0, 1, 0));
        // A = 12, B partially 3, then clear
        tbl.push_back(key(CL, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(key(4'h1, 0, 0, 0, 12'h001, 1, 0, 0));
        tbl.push_back(key(4'h2, 0, 0, 0, 12'h012, 2, 0, 0));
        tbl.push_back(key(EN, 12, 0, 0, 12'h000, 0, 1, 0));
        tbl.push_back(key(4'h3, 12, 0, 0, 12'h003, 1, 1, 0));
        tbl.push_back(key(CL, 0, 0, 0, 12'h000, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // reset asserted in WAIT_SUM alongside sum_valid and a key
        step(key(4'h1, 0, 0, 0, 12'h001, 1, 0, 0), "rw_d1");
        step(key(EN, 1, 0, 0, 12'h000, 0, 1, 0), "rw_en1");
        step(key(4'h2, 1, 0, 0, 12'h002, 1, 1, 0), "rw_d2");
        step(key(EN, 1, 2, 1, 12'h000, 0, 1, 0), "rw_start");
        step(mk(0, 0, 4'h0, 0, 1, 2, 0, 12'h000, 0, 1, 0), "rw_wait");
        step(mk(1, 1, 4'h5, 1, 0, 0, 0, 12'h000, 0, 0, 0), "rw_reset");
        step(mk(0, 0, 4'h0, 1, 0, 0, 0, 12'h000, 0, 0, 0), "rw_after");

        // clear while START is showing drops start_suma, no DONE later
        step(key(4'h3, 0, 0, 0, 12'h003, 1, 0, 0), "cs_d3");
        step(key(EN, 3, 0, 0, 12'h000, 0, 1, 0), "cs_en3");
        step(key(4'h4, 3, 0, 0, 12'h004, 1, 1, 0), "cs_d4");
        step(key(EN, 3, 4, 1, 12'h000, 0, 1, 0), "cs_start");
        step(key(CL, 0, 0, 0, 12'h000, 0, 0, 0), "cs_clear");
        step(mk(0, 0, 4'h0, 1, 0, 0, 0, 12'h000, 0, 0, 0), "cs_after");

        key_valid = 1'b0;
        sum_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
